// File: rtl/grid_screen_ctrl.sv
// Light-cycle grid controller: occupancy map, collision engine, renderer port.
// One engine read/write port plus an independent registered pixel read port.
module grid_screen_ctrl #(
    parameter int COORD_W     = 8,
    parameter int GRID_COLS   = 160,
    parameter int GRID_ROWS   = 120,
    parameter int NUM_PLAYERS = 2,
    localparam int OWNER_W    = $clog2(NUM_PLAYERS + 1)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           clear_req,
    input  logic                           tick,
    input  logic [NUM_PLAYERS*COORD_W-1:0] loc_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0] loc_y,
    input  logic [COORD_W-1:0]             pix_x,
    input  logic [COORD_W-1:0]             pix_y,
    output logic [OWNER_W-1:0]             pix_owner,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_PLAYERS-1:0]         alive,
    output logic [NUM_PLAYERS-1:0]         crash,
    output logic                           game_over
);

    localparam int CELLS = GRID_COLS * GRID_ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int PW    = $clog2(NUM_PLAYERS);

    typedef enum logic [2:0] {
        CLEAR, IDLE, CHK_RD, CHK_EV, WRITE, DONE
    } state_t;

    state_t                         state_q;
    logic [AW-1:0]                  clr_addr_q;
    logic [PW-1:0]                  p_q;
    logic [NUM_PLAYERS*COORD_W-1:0] lx_q, ly_q;
    logic [NUM_PLAYERS-1:0]         pend_q, pend_d;
    logic [NUM_PLAYERS-1:0]         alive_q, crash_q;
    logic                           done_q, game_over_q;
    logic [OWNER_W-1:0]             rd_q, pix_q;
    logic [OWNER_W-1:0]             mem_q [CELLS];

    logic [COORD_W-1:0] cur_x, cur_y;
    logic               cur_oob, same, die, last;
    logic [AW-1:0]      cur_addr, pix_addr, waddr;
    logic [OWNER_W-1:0] wdata;
    logic               we, pix_oob;

    always_comb begin
        cur_x    = lx_q[int'(p_q)*COORD_W +: COORD_W];
        cur_y    = ly_q[int'(p_q)*COORD_W +: COORD_W];
        cur_oob  = (int'(cur_x) >= GRID_COLS) || (int'(cur_y) >= GRID_ROWS);
        cur_addr = AW'(int'(cur_y) * GRID_COLS + int'(cur_x));
        last     = (p_q == PW'(NUM_PLAYERS - 1));
        // Head-on: any other alive player landing on the same cell.
        same = 1'b0;
        for (int q = 0; q < NUM_PLAYERS; q++) begin
            if (PW'(q) != p_q && alive_q[q] &&
                lx_q[q*COORD_W +: COORD_W] == cur_x &&
                ly_q[q*COORD_W +: COORD_W] == cur_y)
                same = 1'b1;
        end
        die         = alive_q[p_q] && (cur_oob || rd_q != '0 || same);
        pend_d      = pend_q;
        pend_d[p_q] = pend_q[p_q] | die;
        pix_oob  = (int'(pix_x) >= GRID_COLS) || (int'(pix_y) >= GRID_ROWS);
        pix_addr = AW'(int'(pix_y) * GRID_COLS + int'(pix_x));
        we    = 1'b0;
        waddr = cur_addr;
        wdata = OWNER_W'(p_q) + OWNER_W'(1);
        if (state_q == CLEAR) begin
            we    = 1'b1;
            waddr = clr_addr_q;
            wdata = '0;
        end else if (state_q == WRITE) begin
            we = alive_q[p_q] && !cur_oob;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem_q[waddr] <= wdata;
        if (state_q == CHK_RD)
            rd_q <= cur_oob ? '0 : mem_q[cur_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pix_q <= '0;
        else if (state_q == CLEAR || pix_oob)
            pix_q <= '0;
        else
            pix_q <= mem_q[pix_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            p_q         <= '0;
            lx_q        <= '0;
            ly_q        <= '0;
            pend_q      <= '0;
            alive_q     <= '0;
            crash_q     <= '0;
            done_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                CLEAR: begin
                    if (clr_addr_q == AW'(CELLS - 1)) begin
                        clr_addr_q  <= '0;
                        alive_q     <= '1;
                        crash_q     <= '0;
                        game_over_q <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        clr_addr_q <= clr_addr_q + AW'(1);
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state_q <= CLEAR;
                    end else if (tick) begin
                        lx_q    <= loc_x;
                        ly_q    <= loc_y;
                        p_q     <= '0;
                        pend_q  <= '0;
                        state_q <= CHK_RD;
                    end
                end
                CHK_RD: state_q <= CHK_EV;
                CHK_EV: begin
                    pend_q <= pend_d;
                    if (last) begin
                        // Deaths commit together so every check saw the same alive set.
                        p_q     <= '0;
                        alive_q <= alive_q & ~pend_d;
                        crash_q <= crash_q | pend_d;
                        state_q <= WRITE;
                    end else begin
                        p_q     <= p_q + PW'(1);
                        state_q <= CHK_RD;
                    end
                end
                WRITE: begin
                    if (last) begin
                        p_q     <= '0;
                        state_q <= DONE;
                    end else begin
                        p_q <= p_q + PW'(1);
                    end
                end
                DONE: begin
                    done_q      <= 1'b1;
                    game_over_q <= ($countones(alive_q) <= 1);
                    state_q     <= IDLE;
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign pix_owner = pix_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign alive     = alive_q;
    assign crash     = crash_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_grid_screen_ctrl.sv
// Directed bench for grid_screen_ctrl: clear, update, collisions, bounds,
// ignored ticks and reset abort. Inputs driven and outputs sampled on negedge.
module tb_grid_screen_ctrl;

    localparam int OW = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] loc_x = '0;
    logic [15:0] loc_y = '0;
    logic [7:0]  pix_x = '0;
    logic [7:0]  pix_y = '0;
    logic [OW-1:0] pix_owner;
    logic        busy, done, game_over;
    logic [1:0]  alive, crash;

    int errors = 0;
    int checks = 0;

    grid_screen_ctrl dut (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .tick(tick),
        .loc_x(loc_x), .loc_y(loc_y), .pix_x(pix_x), .pix_y(pix_y),
        .pix_owner(pix_owner), .busy(busy), .done(done), .alive(alive),
        .crash(crash), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic wait_done(input int budget, output int cyc, output bit blow);
        cyc = 0;
        blow = 1'b0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (!busy) blow = 1'b1;
        end
    endtask

    task automatic read_pix(input int x, input int y, output logic [OW-1:0] v);
        pix_x = 8'(x);
        pix_y = 8'(y);
        @(negedge clk);
        v = pix_owner;
    endtask

    task automatic do_tick(input int x0, y0, x1, y1, output int cyc);
        bit blow;
        loc_x = {8'(x1), 8'(x0)};
        loc_y = {8'(y1), 8'(y0)};
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        wait_done(50, cyc, blow);
    endtask

    task automatic do_clear(output int cyc, output bit blow);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        wait_done(20000, cyc, blow);
    endtask

    task automatic test_reset;
        int cyc;
        bit blow;
        logic [OW-1:0] v;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (alive !== 2'b00 || crash !== 2'b00) begin errors++; $display("FAIL rst_flags alive=%b crash=%b want 00/00", alive, crash); end
        checks++; if (game_over !== 1'b0 || pix_owner !== 2'd0) begin errors++; $display("FAIL rst_go_pix go=%b pix=%0d want 0/0", game_over, pix_owner); end
        reset_n = 1'b1;
        wait_done(20000, cyc, blow);
        checks++; if (cyc !== 19201) begin errors++; $display("FAIL clr_lat got %0d want 19201", cyc); end
        checks++; if (blow !== 1'b0) begin errors++; $display("FAIL clr_busy got busy low before done, want high"); end
        checks++; if (alive !== 2'b11 || crash !== 2'b00) begin errors++; $display("FAIL clr_flags alive=%b crash=%b want 11/00", alive, crash); end
        read_pix(5, 5, v);
        checks++; if (v !== 2'd0) begin errors++; $display("FAIL pix55 got %0d want 0", v); end
    endtask

    task automatic test_update;
        int cyc;
        logic [OW-1:0] v;
        do_tick(10, 10, 20, 20, cyc);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL upd_lat got %0d want 7", cyc); end
        checks++; if (alive !== 2'b11 || crash !== 2'b00 || game_over !== 1'b0) begin errors++; $display("FAIL upd_flags alive=%b crash=%b go=%b want 11/00/0", alive, crash, game_over); end
        read_pix(10, 10, v);
        checks++; if (v !== 2'd1) begin errors++; $display("FAIL pix_10_10 got %0d want 1", v); end
        read_pix(20, 20, v);
        checks++; if (v !== 2'd2) begin errors++; $display("FAIL pix_20_20 got %0d want 2", v); end
        read_pix(11, 10, v);
        checks++; if (v !== 2'd0) begin errors++; $display("FAIL pix_11_10 got %0d want 0", v); end
    endtask

    task automatic test_collision;
        int cyc;
        logic [OW-1:0] v;
        do_tick(20, 20, 21, 20, cyc);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL col_lat got %0d want 7", cyc); end
        checks++; if (crash !== 2'b01 || alive !== 2'b10) begin errors++; $display("FAIL col_flags crash=%b alive=%b want 01/10", crash, alive); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL col_go got %b want 1", game_over); end
        read_pix(21, 20, v);
        checks++; if (v !== 2'd2) begin errors++; $display("FAIL pix_21_20 got %0d want 2", v); end
        read_pix(20, 20, v);
        checks++; if (v !== 2'd2) begin errors++; $display("FAIL pix_20_20b got %0d want 2", v); end
        read_pix(10, 10, v);
        checks++; if (v !== 2'd1) begin errors++; $display("FAIL pix_10_10b got %0d want 1", v); end
    endtask

    task automatic test_head_on;
        int cyc;
        bit blow;
        logic [OW-1:0] v;
        do_clear(cyc, blow);
        checks++; if (cyc !== 19201) begin errors++; $display("FAIL req_clr_lat got %0d want 19201", cyc); end
        checks++; if (alive !== 2'b11 || crash !== 2'b00 || game_over !== 1'b0) begin errors++; $display("FAIL req_clr_flags alive=%b crash=%b go=%b want 11/00/0", alive, crash, game_over); end
        read_pix(20, 20, v);
        checks++; if (v !== 2'd0) begin errors++; $display("FAIL pix_cleared got %0d want 0", v); end
        do_tick(30, 40, 30, 40, cyc);
        checks++; if (crash !== 2'b11 || alive !== 2'b00 || game_over !== 1'b1) begin errors++; $display("FAIL head_flags crash=%b alive=%b go=%b want 11/00/1", crash, alive, game_over); end
        read_pix(30, 40, v);
        checks++; if (v !== 2'd0) begin errors++; $display("FAIL pix_30_40 got %0d want 0", v); end
    endtask

    task automatic test_bounds;
        int cyc;
        bit blow;
        logic [OW-1:0] v;
        do_clear(cyc, blow);
        checks++; if (alive !== 2'b11) begin errors++; $display("FAIL oob_clr alive=%b want 11", alive); end
        do_tick(160, 5, 3, 120, cyc);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL oob_lat got %0d want 7", cyc); end
        checks++; if (crash !== 2'b11 || alive !== 2'b00 || game_over !== 1'b1) begin errors++; $display("FAIL oob_flags crash=%b alive=%b go=%b want 11/00/1", crash, alive, game_over); end
        read_pix(160, 5, v);
        checks++; if (v !== 2'd0) begin errors++; $display("FAIL pix_160_5 got %0d want 0", v); end
        read_pix(0, 6, v);
        checks++; if (v !== 2'd0) begin errors++; $display("FAIL pix_alias_0_6 got %0d want 0", v); end
        read_pix(3, 119, v);
        checks++; if (v !== 2'd0) begin errors++; $display("FAIL pix_3_119 got %0d want 0", v); end
    endtask

    task automatic test_back_to_back;
        int ndone, first, cyc;
        bit blow;
        loc_x = {8'd50, 8'd60};
        loc_y = {8'd50, 8'd60};
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        ndone = 0;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) first = k;
            end
            tick = (k == 1);
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL b2b_count got %0d want 1", ndone); end
        checks++; if (first !== 7) begin errors++; $display("FAIL b2b_lat got %0d want 7", first); end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abort_busy busy=%b done=%b want 1/0", busy, done); end
        checks++; if (alive !== 2'b00 || crash !== 2'b00) begin errors++; $display("FAIL abort_flags alive=%b crash=%b want 00/00", alive, crash); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_done(20000, cyc, blow);
        checks++; if (cyc !== 19201) begin errors++; $display("FAIL abort_clr_lat got %0d want 19201", cyc); end
        checks++; if (blow !== 1'b0) begin errors++; $display("FAIL abort_busy_gap got busy low before done, want high"); end
        checks++; if (alive !== 2'b11 || crash !== 2'b00) begin errors++; $display("FAIL abort_end alive=%b crash=%b want 11/00", alive, crash); end
    endtask

    initial begin
        test_reset;
        test_update;
        test_collision;
        test_head_on;
        test_bounds;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grid_screen_ctrl.md
Name: grid_screen_ctrl

Overview:
Parametrised successor to the two-player screen controller. It holds the grid occupancy map (walls/trails) for NUM_PLAYERS light-cycle players. On each game tick it checks every player's new head position for collisions, commits the surviving heads as trail cells, and tracks alive/crash status. A second, independent read port serves the VGA renderer with per-cell owner IDs.

Parameters:
COORD_W, 8, bit width of one x or y coordinate
GRID_COLS, 160, number of valid columns (x < GRID_COLS)
GRID_ROWS, 120, number of valid rows (y < GRID_ROWS)
NUM_PLAYERS, 2, number of players (2..7)
OWNER_W, derived localparam clog2(NUM_PLAYERS+1), cell owner code width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clear_req  in  1  start a full-grid clear; sampled in IDLE only
tick  in  1  start an update with the current loc_x/loc_y; sampled in IDLE only
loc_x  in  NUM_PLAYERS*COORD_W  packed new head x; player i at [i*COORD_W +: COORD_W]
loc_y  in  NUM_PLAYERS*COORD_W  packed new head y; same packing as loc_x
pix_x  in  COORD_W  renderer query column
pix_y  in  COORD_W  renderer query row
pix_owner  out  OWNER_W  owner of the queried cell (0 = empty, i+1 = player i trail)
busy  out  1  engine not in IDLE
done  out  1  one-cycle pulse when a clear or an update completes
alive  out  NUM_PLAYERS  per-player alive flags
crash  out  NUM_PLAYERS  sticky flag; set in the update where the player dies
game_over  out  1  high when popcount(alive) <= 1 after an update

Behaviour:
- Reset (async, reset_n=0): state=CLEAR, clear address=0, busy=1, done=0, alive=0, crash=0, game_over=0, pix_owner=0, latched positions=0.
- Memory: GRID_COLS*GRID_ROWS entries of OWNER_W bits. Address = y*GRID_COLS + x. The engine has one read/write port; the renderer has a separate read-only port.
- States: CLEAR, IDLE, CHK_RD, CHK_EV, WRITE, DONE.
- CLEAR: writes 0 to one cell per cycle in ascending address order. After the last cell is written:
  - alive={NUM_PLAYERS{1}}, crash=0, game_over=0.
  - Go to DONE.
  - Total time is GRID_COLS*GRID_ROWS cycles in CLEAR.
- IDLE: busy=0.
  - clear_req=1 -> CLEAR, even if tick is also 1 (clear wins).
  - Otherwise tick=1 -> latch loc_x/loc_y, set player index p=0, go to CHK_RD.
- CHK_RD: issue a read of player p's cell. Go to CHK_EV.
- CHK_EV: player p is marked to die if it is alive and any of the following hold:
  - x >= GRID_COLS or y >= GRID_ROWS (no memory access is used for this check);
  - the read data is nonzero;
  - another alive player q != p has identical latched coordinates (head-on: both die).
  - Dead players are still stepped, so timing is fixed. If p < NUM_PLAYERS-1: p++, go to CHK_RD. Otherwise p=0, go to WRITE.
- Death marks are held in a pending mask. alive and crash are updated only on entry to WRITE, so all checks use start-of-tick alive values.
- WRITE: one cycle per player. If the player is still alive, write code p+1 at its cell; otherwise perform no write. After the last player, go to DONE.
- DONE: done=1 for exactly one cycle. game_over=(popcount(alive) <= 1). Go to IDLE.
- Update latency: done asserts 3*NUM_PLAYERS+1 cycles after the tick-sampling edge (7 cycles for NUM_PLAYERS=2).
- tick and clear_req while busy=1 are ignored and not queued.
- After game_over is set, further ticks still run the full sequence. Dead players never write.
- Pixel port:
  - pix_owner is registered, with 1-cycle latency from pix_x/pix_y.
  - It returns 0 if pix_x >= GRID_COLS or pix_y >= GRID_ROWS.
  - It is forced to 0 while state=CLEAR.
  - A read of a cell in the same cycle the engine writes it returns the old value.
- Reset mid-update or mid-clear aborts the operation immediately and restarts CLEAR from address 0. No done pulse is produced for the aborted operation.

Test Plan:
- Reset release, no stimulus -> busy=1 for 19200 cycles, then done pulse; alive=2'b11, crash=0; a pix query at (5,5) returns 0 one cycle later.
- Clear complete; tick with P0=(10,10), P1=(20,20) -> done exactly 7 cycles later; alive=11; pix (10,10)->1, (20,20)->2, (11,10)->0.
- After the previous scenario, tick with P0=(20,20), P1=(21,20) -> crash=01, alive=10, game_over=1; cell (21,20)=2; cell (20,20) still 2.
- Fresh clear; tick with P0=(30,40) and P1=(30,40) -> both crash, alive=00, game_over=1, cell (30,40)=0.
- Fresh clear; tick with P0=(160,5) and P1=(3,120) -> both crash (out of bounds), no memory writes; a pix query at (160,5) returns 0.
- Pulse tick again 2 cycles after a tick -> ignored (done count stays 1). Deassert reset_n on the 4th cycle of an update -> busy=1, CLEAR restarts from address 0, no done pulse until the clear completes.
